mux_rr_arbiter: RTL and testbench

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

---
 rtl/mux_rr_arbiter.sv | 100 ++++++++++
 tb/tb_mux_rr_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Four-source round-robin arbiter with registered one-hot grant and mux select.
// Define MUX_ARB_TIMEOUT_EN to force rotation after MAX_HOLD consecutive grant cycles.
//   state | meaning
//   IDLE  | no owner, gnt = 0, select holds its last value
//   GRANT | one source owns the mux, last = owner
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       valid,
  output logic       s0,
  output logic       s1
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state;
  logic [1:0] last;
  logic [1:0] win;
  logic       win_ok;
  logic       others;
  logic       timeout;
  logic       rotate;

  // Walk from the farthest candidate back to last+1 so the nearest set bit wins.
  always_comb begin
    logic [1:0] idx;
    idx    = '0;
    win    = last;
    win_ok = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) begin
        win    = idx;
        win_ok = 1'b1;
      end
    end
  end

  assign others = |(req & ~(4'b0001 << last));
  assign rotate = others && (!req[last] || timeout);

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt;

  assign timeout = (state == GRANT) && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= 8'd0;
    end else if ((state == IDLE && win_ok) || (state == GRANT && rotate)) begin
      hold_cnt <= 8'd0;
    end else if (state == GRANT) begin
      // Timeout with nobody waiting: owner keeps the grant, window starts over.
      hold_cnt <= (hold_cnt == HOLD_LAST) ? 8'd0 : hold_cnt + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      valid <= 1'b0;
      s0    <= 1'b0;
      s1    <= 1'b0;
      last  <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (win_ok) begin
            state    <= GRANT;
            gnt      <= 4'b0001 << win;
            valid    <= 1'b1;
            {s1, s0} <= win;
            last     <= win;
          end
        end
        GRANT: begin
          if (rotate) begin
            gnt      <= 4'b0001 << win;
            {s1, s0} <= win;
            last     <= win;
          end else if (!req[last]) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed vector table, hand sequences,
// and randomized traffic against a cycle-level ownership model.
module tb_mux_rr_arbiter;

  localparam int unsigned MAX_HOLD = 4;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       valid;
  logic       s0;
  logic       s1;

  int total = 0;
  int bad   = 0;

  mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .gnt  (gnt),
    .valid(valid),
    .s0   (s0),
    .s1   (s1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic       valid;
    logic [1:0] sel;
  } vec_t;

  vec_t vecs[19];

  // Model: owner index (-1 = nobody), last owner, select, cycles held so far.
  int m_owner;
  int m_last;
  int m_sel;
  int m_held;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int from, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_sel   = 0;
    m_held  = 0;
  endtask

  task automatic model_grant(input logic [3:0] r);
    m_owner = pick(m_last, r);
    m_last  = m_owner;
    m_sel   = m_owner;
    m_held  = 1;
  endtask

  task automatic model_step(input logic [3:0] r);
    logic [3:0] oth;
    if (m_owner < 0) begin
      if (r != 4'b0000) model_grant(r);
    end else begin
      oth = r & ~(4'b0001 << m_owner);
      if (!r[m_owner]) begin
        if (oth != 4'b0000) model_grant(r);
        else m_owner = -1;
      end else if (TMO && m_held >= int'(MAX_HOLD)) begin
        if (oth != 4'b0000) model_grant(r);
        else m_held = 1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] eg;
    eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    check({tag, "_gnt"}, gnt, eg);
    check({tag, "_valid"}, {3'b0, valid}, {3'b0, m_owner >= 0});
    check({tag, "_sel"}, {2'b0, s1, s0}, 4'(m_sel));
    check({tag, "_onehot"}, 4'($countones(gnt) <= 1), 4'd1);
  endtask

  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] eg;

    // reset, A alone, full rotation with 3-cycle holds, release paths
    vecs[0]  = '{4'b0001, 4'b0001, 1'b1, 2'd0};
    vecs[1]  = '{4'b1111, 4'b0001, 1'b1, 2'd0};
    vecs[2]  = '{4'b1111, 4'b0001, 1'b1, 2'd0};
    vecs[3]  = '{4'b1110, 4'b0010, 1'b1, 2'd1};
    vecs[4]  = '{4'b1111, 4'b0010, 1'b1, 2'd1};
    vecs[5]  = '{4'b1111, 4'b0010, 1'b1, 2'd1};
    vecs[6]  = '{4'b1101, 4'b0100, 1'b1, 2'd2};
    vecs[7]  = '{4'b1111, 4'b0100, 1'b1, 2'd2};
    vecs[8]  = '{4'b1111, 4'b0100, 1'b1, 2'd2};
    vecs[9]  = '{4'b1011, 4'b1000, 1'b1, 2'd3};
    vecs[10] = '{4'b1111, 4'b1000, 1'b1, 2'd3};
    vecs[11] = '{4'b1111, 4'b1000, 1'b1, 2'd3};
    vecs[12] = '{4'b0111, 4'b0001, 1'b1, 2'd0};
    vecs[13] = '{4'b0100, 4'b0100, 1'b1, 2'd2};
    vecs[14] = '{4'b0000, 4'b0000, 1'b0, 2'd2};
    vecs[15] = '{4'b0000, 4'b0000, 1'b0, 2'd2};
    vecs[16] = '{4'b0011, 4'b0001, 1'b1, 2'd0};
    vecs[17] = '{4'b0010, 4'b0010, 1'b1, 2'd1};
    vecs[18] = '{4'b1001, 4'b1000, 1'b1, 2'd3};

    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_gnt", gnt, 4'b0000);
    check("reset_valid", {3'b0, valid}, 4'b0000);
    check("reset_sel", {2'b0, s1, s0}, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_gnt", gnt, 4'b0000);

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].req);
      check($sformatf("vec%0d_gnt", i), gnt, vecs[i].gnt);
      check($sformatf("vec%0d_valid", i), {3'b0, valid}, {3'b0, vecs[i].valid});
      check($sformatf("vec%0d_sel", i), {2'b0, s1, s0}, {2'b0, vecs[i].sel});
    end

    // asynchronous reset in the middle of D's grant
    req = 4'b1001;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", gnt, 4'b0000);
    check("async_rst_valid", {3'b0, valid}, 4'b0000);
    check("async_rst_sel", {2'b0, s1, s0}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1001);
    check("post_rst_gnt", gnt, 4'b0001);
    check("post_rst_sel", {2'b0, s1, s0}, 4'b0000);

    // two sources holding requests constantly: timeout alternation or a permanent A
    do_reset();
    for (int n = 0; n < 16; n++) begin
      step(4'b0011);
      eg = (TMO && ((n / int'(MAX_HOLD)) % 2 == 1)) ? 4'b0010 : 4'b0001;
      check($sformatf("hold%0d_gnt", n), gnt, eg);
    end

    // randomized traffic against the ownership model
    do_reset();
    check_model("rnd_init");
    r = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 35) r = 4'($urandom_range(0, 15));
      step(r);
      check_model("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
